// File: rtl/conv_pool_engine.sv
// conv_pool_engine: conv window sequencer with ReLU and 2x2 pooling into planar per-kernel maps.
// Defining CONV_POOL_AVGPOOL_EN adds a pool_mode input (latched at start) that selects average pooling.
module conv_pool_engine #(
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int KSIZE      = 5,
    parameter int KERNEL_NUM = 6,
    parameter int DW         = 16,
    parameter int AW         = 16,
    parameter int IN_BASE    = 0,
    parameter int OUT_BASE   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
`ifdef CONV_POOL_AVGPOOL_EN
    input  logic                        pool_mode,
`endif
    output logic                        busy,
    output logic                        done,
    output logic                        rd_en,
    output logic [AW-1:0]               rd_addr,
    input  logic [KSIZE*DW-1:0]         rd_data,
    output logic                        win_valid,
    output logic [3:0]                  win_kidx,
    output logic [KSIZE*KSIZE*DW-1:0]   win_data,
    input  logic                        dot_valid,
    input  logic [DW-1:0]               dot_data,
    output logic                        wr_en,
    output logic [AW-1:0]               wr_addr,
    output logic [DW-1:0]               wr_data
);
    localparam int OUT_W = (IMG_W - KSIZE + 1) / 2;
    localparam int OUT_H = (IMG_H - KSIZE + 1) / 2;
    localparam int KW    = KERNEL_NUM > 1 ? $clog2(KERNEL_NUM) : 1;
    localparam logic [3:0]    K_C   = 4'(KSIZE);
    localparam logic [3:0]    NL_C  = 4'(KERNEL_NUM - 1);
    localparam logic [KW-1:0] RKL   = KW'(KERNEL_NUM - 1);
    localparam logic [AW-1:0] W_A   = AW'(IMG_W);
    localparam logic [AW-1:0] OW_A  = AW'(OUT_W);
    localparam logic [AW-1:0] OH_A  = AW'(OUT_H);
    localparam logic [AW-1:0] PL_A  = AW'(OUT_W * OUT_H);
    localparam logic [AW-1:0] IN_A  = AW'(IN_BASE);
    localparam logic [AW-1:0] OUT_A = AW'(OUT_BASE);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cyc_q, cyc_d;
    logic [1:0]    s_q, s_d;
    logic [AW-1:0] px_q, px_d, py_q, py_d, cx_d, cy_d;
    logic [KW-1:0] rk_q;
    logic [1:0]    rs_q;
    logic [AW-1:0] rpx_q, rpy_q;
    logic [DW+1:0] pool_q [KERNEL_NUM];
    logic [DW+1:0] v, pk, nxt;
    logic          last_q, avg, fetch_rd_d;

    // Next-state sequencing of the (py, px, s, k) loop; cyc counts fetch cycles or kernel index
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q + 1;
        s_d     = s_q;
        px_d    = px_q;
        py_d    = py_q;
        case (state_q)
            IDLE: begin
                cyc_d = '0;
                if (start) state_d = FETCH;
            end
            FETCH: if (cyc_q == K_C) begin
                state_d = ISSUE;
                cyc_d   = '0;
            end
            ISSUE: if (cyc_q == NL_C) begin
                state_d = FETCH;
                cyc_d   = '0;
                s_d     = s_q + 1;
                if (s_q == 2'd3) begin
                    px_d = px_q == OW_A - 1 ? '0 : px_q + 1;
                    if (px_q == OW_A - 1) begin
                        py_d = py_q == OH_A - 1 ? '0 : py_q + 1;
                        if (py_q == OH_A - 1) state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                cyc_d = '0;
                if (wr_en && last_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cx_d       = {px_d[AW-2:0], 1'b0} + AW'(s_d[0]);
    assign cy_d       = {py_d[AW-2:0], 1'b0} + AW'(s_d[1]);
    assign fetch_rd_d = state_d == FETCH && cyc_d < K_C;

    // Sequencer state with registered read, issue and handshake outputs; rows land one cycle after their read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            s_q       <= '0;
            px_q      <= '0;
            py_q      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            win_valid <= 1'b0;
            win_kidx  <= '0;
            win_data  <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            s_q       <= s_d;
            px_q      <= px_d;
            py_q      <= py_d;
            busy      <= state_d != IDLE;
            done      <= state_q == DRAIN && state_d == IDLE;
            rd_en     <= fetch_rd_d;
            rd_addr   <= fetch_rd_d ? IN_A + (cy_d + AW'(cyc_d)) * W_A + cx_d : '0;
            win_valid <= state_d == ISSUE;
            win_kidx  <= state_d == ISSUE ? cyc_d : '0;
            if (state_q == FETCH && cyc_q != 0)
                win_data[(int'(cyc_q) - 1) * KSIZE * DW +: KSIZE * DW] <= rd_data;
        end
    end

`ifdef CONV_POOL_AVGPOOL_EN
    logic mode_q;
    // Pooling mode is latched when a pass is accepted and held for the whole pass
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mode_q <= 1'b0;
        else if (state_q == IDLE && start) mode_q <= pool_mode;
    end
    assign avg = mode_q;
`else
    assign avg = 1'b0;
`endif

    assign v   = dot_data[DW-1] ? '0 : {2'b00, dot_data};
    assign pk  = pool_q[rk_q];
    assign nxt = rs_q == 2'd0 ? v : avg ? pk + v : (pk > v ? pk : v);

    // Result side: counts returns in issue order, pools per kernel, writes on the fourth pool step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk_q    <= '0;
            rs_q    <= '0;
            rpx_q   <= '0;
            rpy_q   <= '0;
            last_q  <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            for (int i = 0; i < KERNEL_NUM; i++) pool_q[i] <= '0;
        end else begin
            wr_en <= 1'b0;
            if (dot_valid && state_q != IDLE) begin
                pool_q[rk_q] <= nxt;
                rk_q         <= rk_q == RKL ? '0 : rk_q + 1;
                wr_en        <= rs_q == 2'd3;
                if (rk_q == RKL) begin
                    rs_q <= rs_q + 1;
                    if (rs_q == 2'd3) begin
                        rpx_q <= rpx_q == OW_A - 1 ? '0 : rpx_q + 1;
                        if (rpx_q == OW_A - 1) rpy_q <= rpy_q == OH_A - 1 ? '0 : rpy_q + 1;
                    end
                end
                if (rs_q == 2'd3) begin
                    wr_addr <= OUT_A + AW'(rk_q) * PL_A + rpy_q * OW_A + rpx_q;
                    wr_data <= avg ? nxt[DW+1:2] : nxt[DW-1:0];
                    last_q  <= rk_q == RKL && rpx_q == OW_A - 1 && rpy_q == OH_A - 1;
                end
            end
        end
    end
endmodule
